// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_add_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/nibble_adder4.sv
// Combinational 4-bit adder slice with carry-in and carry-out.
module nibble_adder4
  import nibble_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_add_seq.sv
// Sequential adder: one 4-bit slice per cycle through a single shared adder.
// Optional subtract mode is enabled by defining NIBBLE_ADD_SEQ_SUB_EN.
module nibble_add_seq
  import nibble_add_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
`ifdef NIBBLE_ADD_SEQ_SUB_EN
  input  logic                         sub,
`endif
  input  logic [SLICE_W*NIBBLES-1:0]   op_a,
  input  logic [SLICE_W*NIBBLES-1:0]   op_b,
  output logic                         busy,
  output logic                         done,
  output logic [SLICE_W*NIBBLES-1:0]   sum,
  output logic                         cout
);

  localparam int unsigned W  = SLICE_W * NIBBLES;
  localparam int unsigned KW = $clog2(NIBBLES);
  localparam logic [KW-1:0] KLast = KW'(NIBBLES - 1);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;

  logic [W-1:0]    b_in;
  logic            cin_init;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
  logic               slice_co;

  // Subtraction is folded into the operand: store ~op_b and seed the carry with 1.
`ifdef NIBBLE_ADD_SEQ_SUB_EN
  assign b_in     = sub ? ~op_b : op_b;
  assign cin_init = sub;
`else
  assign b_in     = op_b;
  assign cin_init = 1'b0;
`endif

  assign slice_a = a_q[k_q*SLICE_W +: SLICE_W];
  assign slice_b = b_q[k_q*SLICE_W +: SLICE_W];

  nibble_adder4 u_adder (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q),
    .s   (slice_s),
    .co  (slice_co)
  );

  // Next-state logic: accept in IDLE, one slice per RUN cycle, single DONE cycle.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = b_in;
          k_d     = '0;
          carry_d = cin_init;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[k_q*SLICE_W +: SLICE_W] = slice_s;
        carry_d = slice_co;
        if (k_q == KLast) begin
          cout_d  = slice_co;
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq (default and NIBBLES=2 instances).
module tb_nibble_add_seq;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned N2 = 2;
  localparam int unsigned W2 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, sub;
  logic [W-1:0]  op_a, op_b, sum;
  logic          busy, done, cout;

  logic          start2;
  logic [W2-1:0] op_a2, op_b2, sum2;
  logic          busy2, done2, cout2;

  int checks = 0;
  int passed = 0;

  nibble_add_seq #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    .sub   (sub),
`endif
    .op_a  (op_a),
    .op_b  (op_b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  nibble_add_seq #(.NIBBLES(N2)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .start (start2),
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    .sub   (1'b0),
`endif
    .op_a  (op_a2),
    .op_b  (op_b2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
  );

  // Reference: plain arithmetic on the whole operands.
  function automatic logic [W:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic [W:0] r;
    if (s) begin
      r[W-1:0] = a - b;
      r[W]     = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b};
    end
    return r;
  endfunction

  // Accept one operation, scramble inputs while it runs, stop at the done cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output int done_cyc, output bit busy_ok);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; sub = s;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = -1;
    busy_ok  = 1'b1;
    for (int c = 1; c <= int'(N) + 6; c++) begin
      @(negedge clk);
      op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
      if (busy !== (c <= int'(N))) busy_ok = 1'b0;
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start2 = 1'b0; sub = 1'b0;
    op_a = '0; op_b = '0; op_a2 = '0; op_b2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (sum !== '0) $display("FAIL reset_sum got %h want 0", sum); else passed++;
    checks++; if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout); else passed++;
    checks++; if (busy2 !== 1'b0 || sum2 !== '0)
      $display("FAIL reset_dut2 got busy=%b sum=%h want 0/0", busy2, sum2); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [3] = '{16'h0000, 16'h0FFF, 16'hFFFF};
    logic [W-1:0] vb [3] = '{16'h0000, 16'h0001, 16'hFFFF};
    logic [W:0]   ex;
    int dc; bit bok;
    for (int i = 0; i < 3; i++) begin
      ex = ref_model(va[i], vb[i], 1'b0);
      do_op(va[i], vb[i], 1'b0, dc, bok);
      checks++; if (dc != int'(N) + 1)
        $display("FAIL dir%0d_latency got %0d want %0d", i, dc, N + 1); else passed++;
      checks++; if (!bok) $display("FAIL dir%0d_busy_window got bad want 1..%0d", i, N);
      else passed++;
      checks++; if (sum !== ex[W-1:0])
        $display("FAIL dir%0d_sum got %h want %h", i, sum, ex[W-1:0]); else passed++;
      checks++; if (cout !== ex[W])
        $display("FAIL dir%0d_cout got %b want %b", i, cout, ex[W]); else passed++;
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0)
        $display("FAIL dir%0d_after_done got done=%b busy=%b want 0/0", i, done, busy);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         s;
    logic [W:0]   ex;
    int dc; bit bok;
    for (int i = 0; i < 16; i++) begin
      a = W'($urandom); b = W'($urandom);
`ifdef NIBBLE_ADD_SEQ_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      ex = ref_model(a, b, s);
      do_op(a, b, s, dc, bok);
      checks++; if (dc != int'(N) + 1 || !bok)
        $display("FAIL rnd%0d_timing got done_cyc=%0d busy_ok=%0d want %0d/1", i, dc, bok, N + 1);
      else passed++;
      checks++; if ({cout, sum} !== ex)
        $display("FAIL rnd%0d_result a=%h b=%h s=%b got %b_%h want %b_%h",
                 i, a, b, s, cout, sum, ex[W], ex[W-1:0]);
      else passed++;
      // Result must hold through idle cycles with garbage on the inputs.
      repeat (3) begin
        @(negedge clk);
        op_a = W'($urandom); op_b = W'($urandom);
      end
      checks++; if ({cout, sum} !== ex)
        $display("FAIL rnd%0d_hold got %b_%h want %b_%h", i, cout, sum, ex[W], ex[W-1:0]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] ex1, ex2;
    int dc;
    ex1 = ref_model(16'h1234, 16'h1111, 1'b0);
    ex2 = ref_model(16'h0F0F, 16'h00F1, 1'b0);
    @(negedge clk);
    start = 1'b1; op_a = 16'h1234; op_b = 16'h1111; sub = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++; if (busy !== (c <= 4) || done !== (c == 5))
        $display("FAIL b2b_cycle%0d got busy=%b done=%b want %b/%b", c, busy, done,
                 (c <= 4), (c == 5));
      else passed++;
      start = (c == 2 || c == 5);
      op_a = 16'hAAAA; op_b = 16'h5555;
    end
    checks++; if ({cout, sum} !== ex1)
      $display("FAIL b2b_first_result got %b_%h want %b_%h", cout, sum, ex1[W], ex1[W-1:0]);
    else passed++;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL b2b_cycle6_idle got busy=%b done=%b want 0/0", busy, done); else passed++;
    start = 1'b1; op_a = 16'h0F0F; op_b = 16'h00F1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL b2b_new_accept got busy=%b want 1", busy);
    else passed++;
    dc = -1;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dc = c;
        break;
      end
    end
    checks++; if (dc != 5) $display("FAIL b2b_new_latency got %0d want 5", dc); else passed++;
    checks++; if ({cout, sum} !== ex2)
      $display("FAIL b2b_new_result got %b_%h want %b_%h", cout, sum, ex2[W], ex2[W-1:0]);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    @(negedge clk);
    start = 1'b1; op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passed++;
    checks++; if (sum !== '0 || cout !== 1'b0)
      $display("FAIL midrst_result got %b_%h want 0_0000", cout, sum); else passed++;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done) $display("FAIL midrst_quiet got activity want none"); else passed++;
    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op_a = 16'h4321; op_b = 16'h1234;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || sum !== '0)
      $display("FAIL rst_priority got busy=%b sum=%h want 0/0000", busy, sum); else passed++;
  endtask

  task automatic test_n2();
    logic [W2-1:0] va [2] = '{8'hFF, 8'h3C};
    logic [W2-1:0] vb [2] = '{8'h01, 8'h5A};
    logic [W2:0]   ex;
    int dc;
    for (int i = 0; i < 2; i++) begin
      ex = {1'b0, va[i]} + {1'b0, vb[i]};
      @(negedge clk);
      start2 = 1'b1; op_a2 = va[i]; op_b2 = vb[i];
      @(posedge clk);
      #1 start2 = 1'b0;
      dc = -1;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        op_a2 = 8'($urandom);
        if (done2 === 1'b1) begin
          dc = c;
          break;
        end
      end
      checks++; if (dc != int'(N2) + 1)
        $display("FAIL n2_%0d_latency got %0d want %0d", i, dc, N2 + 1); else passed++;
      checks++; if ({cout2, sum2} !== ex)
        $display("FAIL n2_%0d_result got %b_%h want %b_%h", i, cout2, sum2, ex[W2], ex[W2-1:0]);
      else passed++;
    end
  endtask

`ifdef NIBBLE_ADD_SEQ_SUB_EN
  task automatic test_sub();
    int dc; bit bok;
    do_op(16'h0005, 16'h0007, 1'b1, dc, bok);
    checks++; if (sum !== 16'hFFFE || cout !== 1'b0 || dc != int'(N) + 1)
      $display("FAIL sub_5m7 got %b_%h cyc %0d want 0_fffe cyc %0d", cout, sum, dc, N + 1);
    else passed++;
    do_op(16'h0007, 16'h0005, 1'b1, dc, bok);
    checks++; if (sum !== 16'h0002 || cout !== 1'b1 || !bok)
      $display("FAIL sub_7m5 got %b_%h busy_ok=%0d want 1_0002", cout, sum, bok);
    else passed++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_n2();
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    test_sub();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4: number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1: request to add; accepted only in IDLE.
REQ-005 The block SHALL have port op_a, input, W: first operand; sampled only on the accepting edge.
REQ-006 The block SHALL have port op_b, input, W: second operand; sampled only on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1: high while in RUN.
REQ-008 The block SHALL have port done, output, 1: one-cycle pulse when the result becomes valid.
REQ-009 The block SHALL have port sum, output, W: result register.
REQ-010 The block SHALL have port cout, output, 1: carry out of the most-significant slice.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE with start=1, the block SHALL latch op_a/op_b, clear slice index k and carry register, and enter RUN; with start=0 it SHALL stay in IDLE.
REQ-013 In each RUN cycle, the block SHALL add slice k of A and B plus the carry register, write the 4-bit result into sum[4k+3:4k], store the slice carry, and increment k.
REQ-014 When k = NIBBLES-1 completes, the block SHALL go RUN->DONE and load cout from the final slice carry; DONE SHALL last exactly one cycle and then return to IDLE.
REQ-015 Latency SHALL be fixed: start accepted at edge 0; busy high for cycles 1..NIBBLES; done high in cycle NIBBLES+1 only.
REQ-016 sum and cout SHALL hold their values from DONE until the next start is accepted; unwritten upper slices SHALL be cleared on acceptance.
REQ-017 start asserted while in RUN or DONE SHALL be ignored; start is not queued.
REQ-018 Changes to op_a/op_b after acceptance SHALL have no effect on the running operation.
REQ-019 The result SHALL be (op_a + op_b) mod 2^W, with cout = bit W of the full sum.

Reset
REQ-020 With rst=1 at an edge, the block SHALL force IDLE, busy=0, done=0, sum=0, cout=0, k=0 and carry=0 in every state, including mid-RUN; the partial result is discarded.
REQ-021 rst SHALL take priority over start in the same cycle.

Configuration
REQ-022 With macro NIBBLE_ADD_SEQ_SUB_EN defined, the block SHALL add input port sub (1 bit, sampled with the operands): sub=1 computes op_a - op_b as op_a + ~op_b + 1, with initial carry 1; cout=1 means no borrow.
REQ-023 Without NIBBLE_ADD_SEQ_SUB_EN, the sub port SHALL NOT exist and the block SHALL add only; latency is identical in both builds.

Structure
REQ-024 A shared package nibble_add_pkg SHALL hold the state enum type (IDLE/RUN/DONE) and the slice width constant SLICE_W = 4.
REQ-025 The combinational 4-bit adder with carry-in and carry-out SHALL be one sub-module, nibble_adder4, instantiated once and reused every RUN cycle; there SHALL be no other sub-modules.

Verification
REQ-026 Reset then start with 0x0000 + 0x0000 -> done in cycle 5, sum=0x0000, cout=0; busy high in cycles 1-4.
REQ-027 0x0FFF + 0x0001 -> sum=0x1000, cout=0; 0xFFFF + 0xFFFF -> sum=0xFFFE, cout=1.
REQ-028 start re-pulsed in cycles 2 and 5 with other operands -> ignored; result is from the first operands; a new start in cycle 6 is accepted.
REQ-029 rst asserted in cycle 3 of RUN -> next cycle IDLE, busy=0, done never pulses, sum=0, cout=0.
REQ-030 NIBBLES=2: 0xFF + 0x01 -> sum=0x00, cout=1, done in cycle 3.
REQ-031 NIBBLE_ADD_SEQ_SUB_EN build: sub=1, 0x0005 - 0x0007 -> sum=0xFFFE, cout=0; 0x0007 - 0x0005 -> sum=0x0002, cout=1.
